// File: rtl/srio_swrite_unpack_mc.sv
// srio_swrite_unpack_mc: strips the header beat off SRIO SWRITE packets and
// routes the payload to one of N_CH channels. The channel is chosen by a
// base/mask address table.
// Optional statistics counters are enabled by `define SRIO_SWRITE_UNPACK_STATS_EN.
module srio_swrite_unpack_mc #(
    parameter int N_CH      = 4,
    parameter int MAX_BEATS = 32,
    parameter int CW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic          AXIS_ACLK,
    input  logic          AXIS_ARESET,
    input  logic [63:0]   S_AXIS_TDATA,
    input  logic          S_AXIS_TVALID,
    input  logic          S_AXIS_TLAST,
    output logic          S_AXIS_TREADY,
    output logic [63:0]   M_AXIS_TDATA,
    output logic          M_AXIS_TVALID,
    output logic          M_AXIS_TLAST,
    input  logic          M_AXIS_TREADY,
    output logic [CW-1:0] M_AXIS_TDEST,
    output logic [7:0]    M_AXIS_TID,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_sel,
    input  logic [33:0]   cfg_base,
    input  logic [33:0]   cfg_mask,
    input  logic          cfg_en,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   trunc_cnt
);

    localparam int BW = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);
    localparam logic [3:0] FTYPE_SWRITE = 4'h6;

    typedef enum logic [1:0] {ST_HDR, ST_PASS, ST_DROP} state_t;

    state_t        r_state;
    logic [33:0]   r_base [N_CH];
    logic [33:0]   r_mask [N_CH];
    logic          r_en   [N_CH];
    logic [CW-1:0] r_ch;
    logic [7:0]    r_srcid;
    logic [BW-1:0] r_beat;
    logic [63:0]   r_m_data;
    logic          r_m_valid;
    logic          r_m_last;
    logic [CW-1:0] r_m_dest;
    logic [7:0]    r_m_id;

    logic [3:0]    w_ftype;
    logic [7:0]    w_srcid;
    logic [33:0]   w_addr;
    logic          w_hit;
    logic [CW-1:0] w_idx;
    logic          w_s_ready;
    logic          w_in_hs;
    logic          w_hdr_ok;

    assign w_ftype  = S_AXIS_TDATA[63:60];
    assign w_srcid  = S_AXIS_TDATA[55:48];
    assign w_addr   = S_AXIS_TDATA[33:0];
    assign w_in_hs  = S_AXIS_TVALID && w_s_ready;
    assign w_hdr_ok = (w_ftype == FTYPE_SWRITE) && w_hit && !S_AXIS_TLAST;

    // Input ready: held low in reset, gated by the output slot only while passing payload
    always_comb begin
        w_s_ready = 1'b1;
        if (AXIS_ARESET) begin
            w_s_ready = 1'b0;
        end else if (r_state == ST_PASS) begin
            w_s_ready = !r_m_valid || M_AXIS_TREADY;
        end
    end

    // Address decode against the channel table; scanning downward lets the lowest index win
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (r_en[i] && ((w_addr & r_mask[i]) == (r_base[i] & r_mask[i]))) begin
                w_hit = 1'b1;
                w_idx = CW'(i);
            end
        end
    end

    // Channel table write port; selects beyond N_CH match no entry and are ignored
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            for (int i = 0; i < N_CH; i++) begin
                r_base[i] <= '0;
                r_mask[i] <= '0;
                r_en[i]   <= 1'b0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < N_CH; i++) begin
                if (32'(cfg_sel) == i) begin
                    r_base[i] <= cfg_base;
                    r_mask[i] <= cfg_mask;
                    r_en[i]   <= cfg_en;
                end
            end
        end
    end

    // Packet FSM plus output register; the channel and source ID are latched at the header, so later table writes only affect the next packet
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_state   <= ST_HDR;
            r_ch      <= '0;
            r_srcid   <= '0;
            r_beat    <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_dest  <= '0;
            r_m_id    <= '0;
        end else begin
            if (r_m_valid && M_AXIS_TREADY) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                ST_HDR: begin
                    if (w_in_hs) begin
                        if (w_hdr_ok) begin
                            r_state <= ST_PASS;
                            r_ch    <= w_idx;
                            r_srcid <= w_srcid;
                            r_beat  <= '0;
                        end else if (!S_AXIS_TLAST) begin
                            r_state <= ST_DROP;
                        end
                    end
                end
                ST_PASS: begin
                    if (w_in_hs) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= S_AXIS_TDATA;
                        r_m_dest  <= r_ch;
                        r_m_id    <= r_srcid;
                        if (S_AXIS_TLAST) begin
                            r_m_last <= 1'b1;
                            r_state  <= ST_HDR;
                        end else if (r_beat == LAST_BEAT) begin
                            r_m_last <= 1'b1;
                            r_state  <= ST_DROP;
                        end else begin
                            r_m_last <= 1'b0;
                            r_beat   <= r_beat + 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_in_hs && S_AXIS_TLAST) begin
                        r_state <= ST_HDR;
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    assign S_AXIS_TREADY = w_s_ready;
    assign M_AXIS_TDATA  = r_m_data;
    assign M_AXIS_TVALID = r_m_valid;
    assign M_AXIS_TLAST  = r_m_last;
    assign M_AXIS_TDEST  = r_m_dest;
    assign M_AXIS_TID    = r_m_id;

`ifdef SRIO_SWRITE_UNPACK_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_trunc_cnt;
    logic        w_drop_evt;
    logic        w_trunc_evt;

    assign w_drop_evt  = (r_state == ST_HDR) && w_in_hs && !w_hdr_ok;
    assign w_trunc_evt = (r_state == ST_PASS) && w_in_hs && !S_AXIS_TLAST && (r_beat == LAST_BEAT);

    // Saturating drop and truncation statistics
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            r_drop_cnt  <= '0;
            r_trunc_cnt <= '0;
        end else begin
            if (w_drop_evt && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_trunc_evt && (r_trunc_cnt != 16'hFFFF)) begin
                r_trunc_cnt <= r_trunc_cnt + 16'd1;
            end
        end
    end

    assign drop_cnt  = r_drop_cnt;
    assign trunc_cnt = r_trunc_cnt;
`else
    assign drop_cnt  = 16'd0;
    assign trunc_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_srio_swrite_unpack_mc.sv
// Directed testbench for srio_swrite_unpack_mc (N_CH=4, MAX_BEATS=32).
module tb_srio_swrite_unpack_mc;

    logic        clk;
    logic        rst;
    logic [63:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic [63:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;
    logic [1:0]  M_AXIS_TDEST;
    logic [7:0]  M_AXIS_TID;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [33:0] cfg_base;
    logic [33:0] cfg_mask;
    logic        cfg_en;
    logic [15:0] drop_cnt;
    logic [15:0] trunc_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int max_wait = 0;
    int stall_err = 0;
    logic bp_en = 1'b0;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [1:0]  dest;
        logic [7:0]  id;
    } beat_t;

    beat_t outq[$];
    beat_t held;
    beat_t cur;
    logic  held_v = 1'b0;

    srio_swrite_unpack_mc #(.N_CH(4), .MAX_BEATS(32)) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TDEST(M_AXIS_TDEST), .M_AXIS_TID(M_AXIS_TID),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_base(cfg_base),
        .cfg_mask(cfg_mask), .cfg_en(cfg_en),
        .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cur = {M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TDEST, M_AXIS_TID};

    // Output monitor: collects handshaken beats and flags any change while stalled
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v && (!M_AXIS_TVALID || cur != held)) stall_err++;
            if (M_AXIS_TVALID && M_AXIS_TREADY) outq.push_back(cur);
            held_v = M_AXIS_TVALID && !M_AXIS_TREADY;
            held = cur;
        end
    end

    // Random sink back-pressure when enabled
    always @(posedge clk) begin
        #1;
        if (bp_en) M_AXIS_TREADY = 1'($urandom_range(0, 1));
    end

    function automatic logic [63:0] hdr(input logic [3:0] ft, input logic [7:0] sid, input logic [33:0] a);
        return {ft, 4'h0, sid, 14'h0, a};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic l);
        int n = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        @(negedge clk);
        while (!S_AXIS_TREADY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n > max_wait) max_wait = n;
        if (n >= 200) begin
            chk_cnt++;
            $display("[TB] FAIL send_timeout: TREADY low for %0d cycles, want handshake", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [33:0] b, input logic [33:0] m, input logic e);
        cfg_sel = sel; cfg_base = b; cfg_mask = m; cfg_en = e; cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic idle_cycle();
        S_AXIS_TVALID = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        S_AXIS_TVALID = 0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 0;
        M_AXIS_TREADY = 1; cfg_we = 0; cfg_sel = 0; cfg_base = 0; cfg_mask = 0; cfg_en = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (S_AXIS_TREADY !== 1'b0) $display("[TB] FAIL reset_tready: got %0b want 0", S_AXIS_TREADY);
        else pass_cnt++;
        chk_cnt++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TDEST, M_AXIS_TID} !== 76'd0)
            $display("[TB] FAIL reset_outputs: got v=%0b l=%0b d=%h dest=%0d id=%h want all 0",
                     M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TDEST, M_AXIS_TID);
        else pass_cnt++;
        chk_cnt++;
        if ({drop_cnt, trunc_cnt} !== 32'd0) $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", drop_cnt, trunc_cnt);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (S_AXIS_TREADY !== 1'b1) $display("[TB] FAIL hdr_tready: got %0b want 1", S_AXIS_TREADY);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        beat_t exp;
        cfg_write(2'd2, 34'h0_1000_0000, 34'h3_F000_0000, 1'b1);
        outq.delete();
        send_beat(hdr(4'h6, 8'h5A, 34'h0_1000_0040), 1'b0);
        chk_cnt++;
        if (M_AXIS_TVALID !== 1'b0) $display("[TB] FAIL basic_hdr_hidden: got valid=%0b want 0", M_AXIS_TVALID);
        else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            send_beat(64'hD000_0000_0000_0000 + 64'(b), b == 3);
            exp = {64'hD000_0000_0000_0000 + 64'(b), 1'(b == 3), 2'd2, 8'h5A};
            chk_cnt++;
            if (M_AXIS_TVALID !== 1'b1 || cur !== exp)
                $display("[TB] FAIL basic_beat%0d: got v=%0b %h want v=1 %h", b, M_AXIS_TVALID, cur, exp);
            else pass_cnt++;
        end
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 4 || M_AXIS_TVALID !== 1'b0)
            $display("[TB] FAIL basic_count: got %0d beats valid=%0b want 4 valid=0", outq.size(), M_AXIS_TVALID);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        cfg_write(2'd0, 34'h0_1000_0000, 34'h3_F000_0000, 1'b1);
        cfg_write(2'd3, 34'h0_1000_0000, 34'h0_F000_0000, 1'b1);
        outq.delete();
        send_beat(hdr(4'h6, 8'h33, 34'h0_1000_0040), 1'b0);
        send_beat(64'h1, 1'b0);
        send_beat(64'h2, 1'b1);
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 2 || outq[0].dest !== 2'd0 || outq[1].dest !== 2'd0 || outq[1].id !== 8'h33)
            $display("[TB] FAIL priority_dest: got %0d beats dest=%0d want 2 beats dest=0",
                     outq.size(), (outq.size() > 0) ? outq[0].dest : 2'd3);
        else pass_cnt++;
    endtask

    task automatic test_drop();
        int exp_drop;
        outq.delete();
        max_wait = 0;
        send_beat(hdr(4'h5, 8'h11, 34'h0_1000_0040), 1'b0);
        for (int b = 0; b < 8; b++) send_beat(64'hAA00 + 64'(b), b == 7);
        send_beat(hdr(4'h6, 8'h12, 34'h2_0000_0000), 1'b0);
        for (int b = 0; b < 8; b++) send_beat(64'hBB00 + 64'(b), b == 7);
        send_beat(hdr(4'h6, 8'h13, 34'h0_1000_0040), 1'b1);
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 0) $display("[TB] FAIL drop_output: got %0d beats want 0", outq.size());
        else pass_cnt++;
        chk_cnt++;
        if (max_wait !== 0) $display("[TB] FAIL drop_tready: got %0d stall cycles want 0", max_wait);
        else pass_cnt++;
`ifdef SRIO_SWRITE_UNPACK_STATS_EN
        exp_drop = 3;
`else
        exp_drop = 0;
`endif
        chk_cnt++;
        if (drop_cnt !== 16'(exp_drop)) $display("[TB] FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
        else pass_cnt++;
    endtask

    task automatic test_trunc();
        int bad;
        int exp_trunc;
        outq.delete();
        send_beat(hdr(4'h6, 8'h44, 34'h0_1000_0000), 1'b0);
        for (int b = 0; b < 40; b++) send_beat(64'hC000 + 64'(b), b == 39);
        idle_cycle();
        bad = 0;
        for (int i = 0; i < outq.size(); i++)
            if (outq[i].d !== 64'hC000 + 64'(i) || outq[i].l !== (i == 31)) bad++;
        chk_cnt++;
        if (outq.size() !== 32 || bad !== 0) $display("[TB] FAIL trunc_beats: got %0d beats %0d bad want 32 beats 0 bad", outq.size(), bad);
        else pass_cnt++;
        outq.delete();
        send_beat(hdr(4'h6, 8'h45, 34'h0_1000_0000), 1'b0);
        for (int b = 0; b < 32; b++) send_beat(64'hE000 + 64'(b), b == 31);
        send_beat(hdr(4'h6, 8'h46, 34'h0_1000_0000), 1'b0);
        for (int b = 0; b < 3; b++) send_beat(64'hF000 + 64'(b), b == 2);
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 35 || outq[31].l !== 1'b1 || outq[34].l !== 1'b1 || outq[34].d !== 64'hF002 || outq[34].id !== 8'h46)
            $display("[TB] FAIL trunc_follow: got %0d beats want 35 with last at 31 and 34", outq.size());
        else pass_cnt++;
`ifdef SRIO_SWRITE_UNPACK_STATS_EN
        exp_trunc = 1;
`else
        exp_trunc = 0;
`endif
        chk_cnt++;
        if (trunc_cnt !== 16'(exp_trunc)) $display("[TB] FAIL trunc_cnt: got %0d want %0d", trunc_cnt, exp_trunc);
        else pass_cnt++;
    endtask

    task automatic test_table_during_pass();
        outq.delete();
        send_beat(hdr(4'h6, 8'h77, 34'h0_1000_0040), 1'b0);
        send_beat(64'h71, 1'b0);
        S_AXIS_TVALID = 1'b0;
        cfg_write(2'd0, 34'h0_1000_0000, 34'h3_F000_0000, 1'b0);
        send_beat(64'h72, 1'b0);
        send_beat(64'h73, 1'b1);
        send_beat(hdr(4'h6, 8'h78, 34'h0_1000_0040), 1'b0);
        send_beat(64'h74, 1'b1);
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 4 || outq[2].dest !== 2'd0 || outq[2].d !== 64'h73 || outq[3].dest !== 2'd2)
            $display("[TB] FAIL table_during_pass: got %0d beats want 4 with dest 0,0,0,2", outq.size());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        beat_t expq[$];
        int len;
        int bad;
        int n;
        cfg_write(2'd0, 34'h0_1000_0000, 34'h3_F000_0000, 1'b1);
        outq.delete();
        stall_err = 0;
        bp_en = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 6);
            send_beat(hdr(4'h6, 8'(p), 34'h0_1000_0100), 1'b0);
            for (int b = 0; b < len; b++) begin
                send_beat({32'(p), 32'(b)}, b == len - 1);
                expq.push_back({{32'(p), 32'(b)}, 1'(b == len - 1), 2'd0, 8'(p)});
            end
        end
        S_AXIS_TVALID = 1'b0;
        n = 0;
        while (outq.size() < expq.size() && n < 1000) begin
            @(posedge clk);
            n++;
        end
        bp_en = 1'b0;
        #2;
        M_AXIS_TREADY = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < expq.size() && i < outq.size(); i++)
            if (outq[i] !== expq[i]) bad++;
        chk_cnt++;
        if (outq.size() !== expq.size() || bad !== 0)
            $display("[TB] FAIL bp_stream: got %0d beats %0d bad want %0d beats 0 bad", outq.size(), bad, expq.size());
        else pass_cnt++;
        chk_cnt++;
        if (stall_err !== 0) $display("[TB] FAIL bp_stable: got %0d changes while stalled want 0", stall_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int exp_drop;
        send_beat(hdr(4'h6, 8'h90, 34'h0_1000_0000), 1'b0);
        send_beat(64'h91, 1'b0);
        send_beat(64'h92, 1'b0);
        chk_cnt++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 64'h92)
            $display("[TB] FAIL rstmid_pre: got v=%0b d=%h want v=1 d=92", M_AXIS_TVALID, M_AXIS_TDATA);
        else pass_cnt++;
        S_AXIS_TDATA = 64'h93;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (M_AXIS_TVALID !== 1'b0 || S_AXIS_TREADY !== 1'b0 || M_AXIS_TDATA !== 64'd0)
            $display("[TB] FAIL rstmid_async: got v=%0b rdy=%0b d=%h want 0 0 0", M_AXIS_TVALID, S_AXIS_TREADY, M_AXIS_TDATA);
        else pass_cnt++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        S_AXIS_TVALID = 1'b0;
        @(posedge clk);
        #1;
        outq.delete();
        send_beat(hdr(4'h6, 8'h94, 34'h0_1000_0000), 1'b0);
        send_beat(64'h95, 1'b1);
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 0) $display("[TB] FAIL rstmid_table_clear: got %0d beats want 0", outq.size());
        else pass_cnt++;
`ifdef SRIO_SWRITE_UNPACK_STATS_EN
        exp_drop = 1;
`else
        exp_drop = 0;
`endif
        chk_cnt++;
        if (drop_cnt !== 16'(exp_drop)) $display("[TB] FAIL rstmid_drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
        else pass_cnt++;
        cfg_write(2'd1, 34'h2_0000_0000, 34'h3_0000_0000, 1'b1);
        send_beat(hdr(4'h6, 8'hA5, 34'h2_1234_5678), 1'b0);
        send_beat(64'hA1, 1'b0);
        send_beat(64'hA2, 1'b1);
        idle_cycle();
        chk_cnt++;
        if (outq.size() !== 2 || outq[0] !== {64'hA1, 1'b0, 2'd1, 8'hA5} || outq[1] !== {64'hA2, 1'b1, 2'd1, 8'hA5})
            $display("[TB] FAIL rstmid_after: got %0d beats want 2 on dest 1 id A5", outq.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_drop();
        test_trunc();
        test_table_during_pass();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/srio_swrite_unpack_mc.md
SRIO_SWRITE_UNPACK_MC -- requirements
Module: srio_swrite_unpack_mc

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of destination channels (1..8).
REQ-002 SHALL have parameter MAX_BEATS, default 32, meaning maximum payload beats (64-bit) per packet before truncation (2..256).
REQ-003 SHALL have parameter CW, default $clog2(N_CH) (minimum 1), meaning channel index width.
REQ-004 AXIS_ACLK  in  1  sole clock; all logic on its rising edge.
REQ-005 AXIS_ARESET  in  1  reset, asynchronous assert, active-high.
REQ-006 S_AXIS_TDATA/TVALID/TLAST  in  64/1/1  SWRITE packet stream; S_AXIS_TREADY  out  1.
REQ-007 M_AXIS_TDATA/TVALID/TLAST  out  64/1/1  payload stream; M_AXIS_TREADY  in  1.
REQ-008 M_AXIS_TDEST  out  CW  matched channel; M_AXIS_TID  out  8  source ID of packet.
REQ-009 cfg_we  in  1; cfg_sel  in  CW; cfg_base  in  34; cfg_mask  in  34; cfg_en  in  1: channel-table write port.
REQ-010 drop_cnt  out  16; trunc_cnt  out  16: saturating statistics.

Function
REQ-011 Header beat (first beat after reset or after a TLAST) SHALL decode: [63:60] FTYPE, [55:48] SRCID, [33:0] ADDR; other bits ignored.
REQ-012 cfg_we=1 SHALL write base/mask/en into entry cfg_sel on the same edge; cfg_sel>=N_CH ignored; all entries reset to base=0, mask=0, en=0.
REQ-013 Channel i SHALL match when en_i=1 and (ADDR & mask_i)==(base_i & mask_i); lowest matching index wins.
REQ-014 FSM states HDR, PASS, DROP; reset state HDR.
REQ-015 HDR: S_AXIS_TREADY=1; on header handshake, FTYPE==4'h6 and a match and TLAST=0 -> PASS, latching channel and SRCID; else -> DROP (or stay HDR if TLAST=1) and count drop.
REQ-016 Header beat SHALL never appear on M_AXIS.
REQ-017 PASS: each accepted payload beat SHALL appear on M_AXIS one cycle later via output register with TDEST/TID latched; S_AXIS_TREADY = !M_AXIS_TVALID | M_AXIS_TREADY.
REQ-018 PASS: input TLAST SHALL be forwarded and return FSM to HDR after that beat.
REQ-019 PASS: beat number MAX_BEATS without TLAST SHALL be emitted with M_AXIS_TLAST=1, trunc_cnt incremented, FSM -> DROP.
REQ-020 DROP: S_AXIS_TREADY=1, beats discarded; beat with TLAST returns FSM to HDR.
REQ-021 M_AXIS_TVALID, once high, SHALL hold with stable TDATA/TLAST/TDEST/TID until M_AXIS_TREADY.
REQ-022 Table writes during PASS SHALL not affect the current packet; they apply from the next header.
REQ-023 Counters SHALL saturate at 16'hFFFF, not wrap.
REQ-024 Sustained throughput in PASS SHALL be one beat per cycle with M_AXIS_TREADY held high.

Reset
REQ-025 AXIS_ARESET high SHALL immediately force: state HDR, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TDEST=0, M_AXIS_TID=0, counters 0, table cleared.
REQ-026 Reset mid-packet SHALL discard the partial packet; first beat after release is a header.
REQ-027 S_AXIS_TREADY SHALL be 0 while AXIS_ARESET is high.

Configuration
REQ-028 Macro SRIO_SWRITE_UNPACK_STATS_EN defined: drop_cnt and trunc_cnt implemented per REQ-015/019/023.
REQ-029 Macro not defined: no counter registers; drop_cnt and trunc_cnt tied to 0; datapath unchanged.

Verification
REQ-030 Ch2 base=0x0_1000_0000 mask=0x3_F000_0000 en; header FTYPE=6 ADDR=0x0_1000_0040 SRCID=0x5A + 4 beats -> 4 beats out TDEST=2 TID=0x5A, TLAST on 4th, latency 1 cycle.
REQ-031 Ch0 and ch3 both match ADDR -> TDEST=0.
REQ-032 FTYPE=5 or no match, 8-beat packet -> nothing on M_AXIS, TREADY=1 throughout, drop_cnt=1.
REQ-033 MAX_BEATS=32, 40-beat payload -> 32 beats out, TLAST on 32nd, remaining 8 consumed, trunc_cnt=1; next packet passes normally.
REQ-034 Random M_AXIS_TREADY back-pressure over 100 packets -> no beat lost/duplicated, output held stable while stalled.
REQ-035 Assert AXIS_ARESET at payload beat 3 -> M_AXIS_TVALID=0 immediately; post-release header accepted and routed correctly.
